wb_regfile_writer: RTL

- Write-back stage that produces the register-file write port (RW, busW, RegWrite) from MEM-stage results.
- Accepts one retiring instruction per handshake and selects ALU result or load data.
- Extracts and sign/zero-extends byte, half and word loads, and suppresses writes to r0.
- Waits for multi-cycle data-memory responses with a watchdog; sits between MEM stage/data memory and the ID-stage register file.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/load_extract.sv | 38 +++
 rtl/wb_regfile_writer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the write-back stage: load sizes, FSM states and the
// hard-wired zero register.
package cpu_pkg;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_LD = 2'b01,
        COMMIT  = 2'b10
    } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational load-lane selection and sign/zero extension of an aligned
// 32-bit memory word; also flags misaligned half/word accesses.
module load_extract
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{addr, 3'b000} +: 8];
        half_v     = addr[1] ? rdata[31:16] : rdata[15:0];
        data       = rdata;
        misaligned = 1'b0;
        case (size)
            LD_BYTE: begin
                data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            LD_HALF: begin
                data       = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
                misaligned = addr[0];
            end
            // reserved size falls through to word behaviour
            default: begin
                data       = rdata;
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: accepts retiring MEM-stage instructions, waits for load
// data under a watchdog, and drives the register-file write port.
module wb_regfile_writer
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [REG_AW-1:0] RW,
    output logic [DATA_W-1:0] busW,
    output logic              RegWrite,
    output logic              err_misalign,
    output logic              err_timeout,
    input  logic              err_clear,
    output logic [31:0]       retire_cnt
);

    wb_state_t         state;
    logic [REG_AW-1:0] cap_rd;
    logic              cap_we;
    logic [1:0]        cap_size;
    logic [1:0]        cap_lane;
    logic              cap_uns;
    logic [TO_W-1:0]   wdog;
    logic [DATA_W-1:0] ld_data;
    logic              ld_mis;
    logic              accept;

    assign in_ready = (state != WAIT_LD);
    assign accept   = in_valid & in_ready;

    load_extract u_extract (
        .rdata       (dmem_rdata),
        .addr        (cap_lane),
        .size        (cap_size),
        .is_unsigned (cap_uns),
        .data        (ld_data),
        .misaligned  (ld_mis)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cap_rd       <= '0;
            cap_we       <= 1'b0;
            cap_size     <= '0;
            cap_lane     <= '0;
            cap_uns      <= 1'b0;
            wdog         <= '0;
            RW           <= '0;
            busW         <= '0;
            RegWrite     <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            retire_cnt   <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (state == COMMIT)
                retire_cnt <= retire_cnt + 32'd1;
            // clear first so a same-cycle set below wins
            if (err_clear) begin
                err_misalign <= 1'b0;
                err_timeout  <= 1'b0;
            end
            case (state)
                IDLE, COMMIT: begin
                    if (accept) begin
                        cap_rd   <= in_rd;
                        cap_we   <= in_reg_write;
                        cap_size <= in_ld_size;
                        cap_lane <= in_alu_result[1:0];
                        cap_uns  <= in_ld_unsigned;
                        if (in_mem_to_reg) begin
                            state <= WAIT_LD;
                            wdog  <= '0;
                        end else begin
                            state    <= COMMIT;
                            RW       <= in_rd;
                            busW     <= in_alu_result;
                            RegWrite <= in_reg_write && (in_rd != REG_AW'(REG_ZERO));
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LD: begin
                    if (dmem_rvalid) begin
                        state    <= COMMIT;
                        RW       <= cap_rd;
                        busW     <= ld_data;
                        RegWrite <= cap_we && (cap_rd != REG_AW'(REG_ZERO)) && !ld_mis;
                        if (ld_mis)
                            err_misalign <= 1'b1;
                    end else if (wdog == TO_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
